// File: rtl/cfo_est_seq_pkg.sv
// Shared state encoding and default timing constants for the CFO-estimation sequencer.
package cfo_est_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_ACCUM,
        ST_ANGLE,
        ST_DONE
    } state_e;

    localparam int ACC_LEN_DEF = 64;
    localparam int GUARD_DEF   = 16;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/cfo_est_seq_if.sv
// Control/status bundle between packet detect, the sequencer and the accumulator/angle blocks.
interface cfo_est_seq_if #(
    parameter int N = 12
) ();

    logic         start;
    logic         abort;
    logic         sample_valid;
    logic [N-1:0] win_len;
    logic         angle_done;
    logic         busy;
    logic         acc_clr;
    logic         acc_en;
    logic [N-1:0] sample_idx;
    logic         angle_start;
    logic         est_valid;
    logic         timeout_err;

    modport master (
        output start, abort, sample_valid, win_len, angle_done,
        input  busy, acc_clr, acc_en, sample_idx, angle_start, est_valid, timeout_err
    );

    modport slave (
        input  start, abort, sample_valid, win_len, angle_done,
        output busy, acc_clr, acc_en, sample_idx, angle_start, est_valid, timeout_err
    );

endinterface

// File: rtl/cfo_est_seq_phase_cnt.sv
// N-bit up counter with synchronous clear/enable; hit_o flags cnt == term_i combinationally.
module phase_cnt #(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [N-1:0] term_i,
    output logic [N-1:0] cnt_o,
    output logic         hit_o
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + N'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/cfo_est_seq.sv
// CFO-estimation sequencer: guard skip, windowed accumulate, angle launch with watchdog.
// All pulses are registered; only acc_en and sample_idx are decoded combinationally.
module cfo_est_seq
    import cfo_est_seq_pkg::*;
#(
    parameter int N       = 12,
    parameter int GUARD   = GUARD_DEF,
    parameter int ACC_LEN = ACC_LEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    cfo_est_seq_if.slave  bus
);

    state_e       state_q, state_d;
    logic [N-1:0] len_q, len_d;
    logic [N-1:0] cnt;
    logic [N-1:0] term;
    logic         cnt_en;
    logic         cnt_clr;
    logic         cnt_hit;

    logic busy_q, busy_d;
    logic acc_clr_q, acc_clr_d;
    logic angle_start_q, angle_start_d;
    logic est_valid_q, est_valid_d;
    logic timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        term          = '0;
        cnt_en        = 1'b0;
        acc_clr_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d     = (bus.win_len == '0) ? N'(ACC_LEN) : bus.win_len;
                    acc_clr_d = 1'b1;
                    state_d   = (GUARD == 0) ? ST_ACCUM : ST_GUARD;
                end
            end
            ST_GUARD: begin
                term   = N'(GUARD - 1);
                cnt_en = bus.sample_valid;
                if (bus.sample_valid && cnt_hit)
                    state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                term   = len_q - N'(1);
                cnt_en = bus.sample_valid;
                if (bus.sample_valid && cnt_hit)
                    state_d = ST_ANGLE;
            end
            ST_ANGLE: begin
                term   = N'(TIMEOUT);
                cnt_en = 1'b1;
                // A completion arriving on the last watchdog cycle still counts as success.
                if (bus.angle_done) begin
                    state_d = ST_DONE;
                end else if (cnt_hit) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a start seen in the same cycle.
        if (bus.abort) begin
            state_d       = ST_IDLE;
            len_d         = len_q;
            acc_clr_d     = 1'b0;
            timeout_err_d = 1'b0;
        end
    end

    assign cnt_clr       = (state_d != state_q);
    assign busy_d        = (state_d != ST_IDLE);
    assign angle_start_d = (state_d == ST_ANGLE) && (state_q != ST_ANGLE);
    assign est_valid_d   = (state_d == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            busy_q        <= 1'b0;
            acc_clr_q     <= 1'b0;
            angle_start_q <= 1'b0;
            est_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            busy_q        <= busy_d;
            acc_clr_q     <= acc_clr_d;
            angle_start_q <= angle_start_d;
            est_valid_q   <= est_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    phase_cnt #(.N(N)) u_phase_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (term),
        .cnt_o  (cnt),
        .hit_o  (cnt_hit)
    );

    assign bus.busy        = busy_q;
    assign bus.acc_clr     = acc_clr_q;
    assign bus.angle_start = angle_start_q;
    assign bus.est_valid   = est_valid_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.acc_en      = (state_q == ST_ACCUM) && bus.sample_valid;
    assign bus.sample_idx  = (state_q == ST_ACCUM) ? cnt : '0;

endmodule

// File: tb/tb_cfo_est_seq.sv
// Directed bench for cfo_est_seq: cycle 0 is the cycle in which start is sampled.
module tb_cfo_est_seq;

    localparam int N = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cfo_est_seq_if #(.N(N)) bus ();

    cfo_est_seq #(.N(N), .GUARD(16), .ACC_LEN(64), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int first_en, last_en, en_cnt, idx_err, gap_cnt;
    int clr_cnt, clr_cyc, as_cnt, as_cyc, ev_cnt, ev_cyc, to_cnt, to_cyc, idle_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one start and records what the DUT does; stops at the first idle cycle.
    task automatic run_txn(input logic [N-1:0] wl0, input bit toggle, input int wl_chg_cyc,
                           input logic [N-1:0] wl_chg_val, input int done_dly,
                           input int abort_cyc, input int max_cyc);
        first_en = -1; last_en = -1; en_cnt = 0; idx_err = 0; gap_cnt = 0;
        clr_cnt = 0; clr_cyc = -1; as_cnt = 0; as_cyc = -1;
        ev_cnt = 0; ev_cyc = -1; to_cnt = 0; to_cyc = -1; idle_cyc = -1;
        bus.win_len = wl0; bus.sample_valid = 1'b0; bus.abort = 1'b0; bus.angle_done = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            bus.sample_valid = toggle ? cyc[0] : 1'b1;
            if (cyc == wl_chg_cyc) bus.win_len = wl_chg_val;
            bus.angle_done = (done_dly >= 0) && (as_cyc >= 0) && (cyc == as_cyc + done_dly);
            bus.abort = (cyc == abort_cyc);
            #1;
            if (bus.acc_clr) begin clr_cnt++; if (clr_cyc < 0) clr_cyc = cyc; end
            if (bus.angle_start) begin as_cnt++; if (as_cyc < 0) as_cyc = cyc; end
            if (bus.est_valid) begin ev_cnt++; if (ev_cyc < 0) ev_cyc = cyc; end
            if (bus.timeout_err) begin to_cnt++; if (to_cyc < 0) to_cyc = cyc; end
            if (bus.acc_en) begin
                if (first_en < 0) first_en = cyc;
                if (bus.sample_idx != en_cnt[N-1:0]) idx_err++;
                en_cnt++;
                last_en = cyc;
            end else if (first_en >= 0 && as_cnt == 0 && bus.busy) begin
                gap_cnt++;
                if (bus.sample_idx != en_cnt[N-1:0]) idx_err++;
            end
            if (!bus.busy) begin
                idle_cyc = cyc;
                break;
            end
            step();
        end
        bus.sample_valid = 1'b0; bus.angle_done = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.sample_valid = 1'b1;
        bus.win_len = '0; bus.angle_done = 1'b0;
        rst = 1'b1;
        step(); step();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.acc_clr, bus.angle_start, bus.est_valid, bus.timeout_err} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {bus.acc_clr, bus.angle_start, bus.est_valid, bus.timeout_err}); end
        checks++; if (bus.acc_en !== 1'b0 || bus.sample_idx !== '0) begin failures++; $display("FAIL reset_acc got=%b/%0d exp=0/0", bus.acc_en, bus.sample_idx); end
        rst = 1'b0; bus.sample_valid = 1'b0;
        step();
    endtask

    task automatic test_main_flow();
        run_txn(12'd64, 1'b0, -1, '0, 3, -1, 200);
        checks++; if (clr_cnt !== 1 || clr_cyc !== 1) begin failures++; $display("FAIL main_acc_clr got=%0d@%0d exp=1@1", clr_cnt, clr_cyc); end
        checks++; if (first_en !== 17) begin failures++; $display("FAIL main_first_en got=%0d exp=17", first_en); end
        checks++; if (en_cnt !== 64) begin failures++; $display("FAIL main_en_cnt got=%0d exp=64", en_cnt); end
        checks++; if (idx_err !== 0) begin failures++; $display("FAIL main_sample_idx errors got=%0d exp=0", idx_err); end
        checks++; if (as_cnt !== 1 || as_cyc !== 81) begin failures++; $display("FAIL main_angle_start got=%0d@%0d exp=1@81", as_cnt, as_cyc); end
        checks++; if (ev_cnt !== 1 || ev_cyc !== 85) begin failures++; $display("FAIL main_est_valid got=%0d@%0d exp=1@85", ev_cnt, ev_cyc); end
        checks++; if (to_cnt !== 0) begin failures++; $display("FAIL main_timeout got=%0d exp=0", to_cnt); end
        checks++; if (idle_cyc !== 86) begin failures++; $display("FAIL main_idle got=%0d exp=86", idle_cyc); end
    endtask

    task automatic test_back_to_back();
        // Still in the first idle cycle after est_valid: restart immediately.
        bus.win_len = 12'd8; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.acc_clr !== 1'b1) begin failures++; $display("FAIL b2b_restart busy/clr got=%b%b exp=11", bus.busy, bus.acc_clr); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_abort busy got=%b exp=0", bus.busy); end
        step();
    endtask

    task automatic test_toggle_valid();
        run_txn(12'd8, 1'b1, -1, '0, -1, 50, 200);
        checks++; if (first_en !== 33) begin failures++; $display("FAIL tog_first_en got=%0d exp=33", first_en); end
        checks++; if (en_cnt !== 8 || last_en !== 47) begin failures++; $display("FAIL tog_en got=%0d last=%0d exp=8 last=47", en_cnt, last_en); end
        checks++; if (as_cyc !== 48) begin failures++; $display("FAIL tog_angle_start got=%0d exp=48", as_cyc); end
        checks++; if (gap_cnt !== 7 || idx_err !== 0) begin failures++; $display("FAIL tog_idx_hold gaps=%0d errs=%0d exp gaps=7 errs=0", gap_cnt, idx_err); end
        checks++; if (ev_cnt !== 0 || to_cnt !== 0 || idle_cyc !== 51) begin failures++; $display("FAIL tog_abort_angle ev=%0d to=%0d idle=%0d exp 0 0 51", ev_cnt, to_cnt, idle_cyc); end
        step();
    endtask

    task automatic test_default_len();
        run_txn(12'd0, 1'b0, 20, 12'd5, 1, -1, 200);
        checks++; if (en_cnt !== 64 || first_en !== 17 || last_en !== 80) begin failures++; $display("FAIL dflt_window got=%0d [%0d..%0d] exp=64 [17..80]", en_cnt, first_en, last_en); end
        checks++; if (idx_err !== 0) begin failures++; $display("FAIL dflt_sample_idx errors got=%0d exp=0", idx_err); end
        checks++; if (as_cyc !== 81 || ev_cyc !== 83 || idle_cyc !== 84) begin failures++; $display("FAIL dflt_tail as=%0d ev=%0d idle=%0d exp 81 83 84", as_cyc, ev_cyc, idle_cyc); end
        step();
    endtask

    task automatic test_timeout();
        run_txn(12'd8, 1'b0, -1, '0, -1, -1, 400);
        checks++; if (as_cyc !== 25) begin failures++; $display("FAIL to_angle_start got=%0d exp=25", as_cyc); end
        checks++; if (to_cnt !== 1 || to_cyc - as_cyc !== 256) begin failures++; $display("FAIL to_pulse got=%0d delta=%0d exp=1 delta=256", to_cnt, to_cyc - as_cyc); end
        checks++; if (ev_cnt !== 0 || idle_cyc !== 281) begin failures++; $display("FAIL to_idle ev=%0d idle=%0d exp 0 281", ev_cnt, idle_cyc); end
        step();
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL to_single got=%b exp=0", bus.timeout_err); end
    endtask

    task automatic test_abort();
        run_txn(12'd64, 1'b0, -1, '0, 3, 27, 200);
        checks++; if (en_cnt !== 11 || idle_cyc !== 28) begin failures++; $display("FAIL abort_accum en=%0d idle=%0d exp 11 28", en_cnt, idle_cyc); end
        checks++; if (as_cnt !== 0 || ev_cnt !== 0 || to_cnt !== 0) begin failures++; $display("FAIL abort_pulses as=%0d ev=%0d to=%0d exp 0 0 0", as_cnt, ev_cnt, to_cnt); end
        step();
        bus.start = 1'b1; bus.abort = 1'b1; bus.win_len = 12'd8;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.acc_clr !== 1'b0) begin failures++; $display("FAIL abort_start busy/clr got=%b%b exp=00", bus.busy, bus.acc_clr); end
        step();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_start_hold busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_in_angle();
        int found;
        int ev;
        bus.win_len = 12'd8; bus.sample_valid = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            if (bus.angle_start) found = 1;
            else step();
        end
        checks++; if (found !== 1) begin failures++; $display("FAIL rst_angle_reach got=%0d exp=1", found); end
        step();
        bus.angle_done = 1'b1; rst = 1'b1;
        step();
        bus.angle_done = 1'b0; rst = 1'b0;
        checks++; if ({bus.busy, bus.acc_clr, bus.angle_start, bus.est_valid, bus.timeout_err, bus.acc_en} !== 6'b0) begin failures++; $display("FAIL rst_angle_outputs got=%b exp=000000", {bus.busy, bus.acc_clr, bus.angle_start, bus.est_valid, bus.timeout_err, bus.acc_en}); end
        checks++; if (bus.sample_idx !== '0) begin failures++; $display("FAIL rst_angle_idx got=%0d exp=0", bus.sample_idx); end
        ev = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.est_valid) ev++;
            step();
        end
        checks++; if (ev !== 0) begin failures++; $display("FAIL rst_angle_no_est got=%0d exp=0", ev); end
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_main_flow();
        test_back_to_back();
        test_toggle_valid();
        test_default_len();
        test_timeout();
        test_abort();
        test_reset_in_angle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
